red_pitaya_fads_sorter: RTL and testbench
=========================================

Name: red_pitaya_fads_sorter

Overview:
Consumer end of the FADS trigger interface. Takes the level sort_trig from the fluorescence detector, detects rising edges and turns each accepted droplet event into a timed actuation. The actuation is a programmable delay, then a one-cycle ASG start strobe plus a gate of programmable width, then a holdoff window. Sits between the detector and the ASG / HV-amplifier path, in the ADC clock domain; config and counters connect to the housekeeping register bus.

Parameters:
DW, 16, width of delay/width/holdoff config fields (cycles)
CW, 32, width of event counters

Ports:
adc_clk_i  in  1  ADC clock, single clock domain
adc_rst_i  in  1  synchronous reset, active-high
sort_trig_i  in  1  detector trigger level (already in adc_clk_i domain)
enable_i  in  1  1 = accept new triggers
delay_i  in  DW  cycles from trigger edge to gate start
width_i  in  DW  gate length in cycles (0 treated as 1)
holdoff_i  in  DW  dead time after gate before re-arming
clear_i  in  1  one-cycle pulse, zeroes both counters
asg_trig_o  out  1  one-cycle start strobe to ASG
sort_gate_o  out  1  actuation gate
busy_o  out  1  high in any state except IDLE
sort_cnt_o  out  CW  accepted sorts
missed_cnt_o  out  CW  edges dropped while busy or disabled

Behaviour:
- Reset (synchronous, adc_rst_i=1 at a clock edge): state IDLE; asg_trig_o, sort_gate_o and busy_o = 0; both counters 0; internal trig_q = 1, so a high input at reset release is not an edge.
- Edge: edge = sort_trig_i & ~trig_q; trig_q <= sort_trig_i every cycle.
- FSM states: IDLE, DELAY, PULSE, HOLDOFF. Down-counter cnt is DW bits.
- IDLE:
  - edge & enable_i at cycle t: latch width_i and holdoff_i; sort_cnt++.
  - If delay_i=0, go to PULSE. Otherwise load cnt=delay_i-1 and go to DELAY.
- DELAY: cnt decrements; at cnt=0, go to PULSE.
- PULSE entry:
  - asg_trig_o=1 for exactly the first PULSE cycle.
  - sort_gate_o=1 for max(width,1) cycles.
  - Then go to HOLDOFF, or to IDLE if holdoff=0.
- HOLDOFF: lasts holdoff cycles, then IDLE. A new edge is accepted in the first IDLE cycle.
- Timing:
  - edge at cycle t → sort_gate_o high at cycle t+1+delay_i.
  - asg_trig_o is coincident with the first sort_gate_o cycle.
  - busy_o is high from t+1.
- Outputs are registered; no combinational path from input to output.
- Missed events: an edge while state≠IDLE, or while IDLE with enable_i=0, increments missed_cnt and does not restart or extend the current sort.
- Config latching: config is latched at acceptance. delay_i is consumed at acceptance (cnt load); width_i and holdoff_i are held in registers. Later config changes affect only the next sort.
- enable_i low mid-sort: the current sort completes normally.
- Counters:
  - Both counters saturate at 2^CW-1.
  - clear_i has priority over a same-cycle increment (result 0).
  - clear_i does not affect the FSM.
- Reset mid-sort: gate drops the cycle after reset; FSM goes to IDLE.

Decomposition:
- Shared package red_pitaya_fads_pkg holds:
  - state enum (IDLE/DELAY/PULSE/HOLDOFF);
  - default DW/CW;
  - low_threshold constant used by the detector.
- One natural sub-module, red_pitaya_fads_satcnt: saturating counter with clear and inc inputs, instantiated twice.

Test Plan:
- delay_i=10, width_i=5, holdoff_i=20, single sort_trig_i rising at cycle 100 → asg_trig_o high only at cycle 111; sort_gate_o high cycles 111–115; busy_o high 101–135; sort_cnt=1, missed_cnt=0.
- delay_i=0, width_i=0, holdoff_i=0 → gate and strobe both one cycle at t+1; busy_o low at t+2; second edge at t+3 accepted, sort_cnt=2.
- Second edge arrives during DELAY, a third during HOLDOFF → one gate only; sort_cnt=1, missed_cnt=2.
- sort_trig_i held high through reset release → no sort. Then low then high → exactly one sort.
- enable_i dropped during PULSE → gate completes full width. Edge while disabled → missed_cnt+1, no gate.
- Force sort_cnt to 2^32-2, two sorts → stays at 2^32-1. clear_i coincident with an accepted edge → sort_cnt=0 and the sort still executes.

Source files
------------

// File: rtl/red_pitaya_fads_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_fads_pkg
//   Shared definitions for the FADS (fluorescence-activated droplet sorting)
//   trigger path: sorter FSM state encoding, default field widths, the
//   detector threshold constant and the debug view of the sorter.
// -----------------------------------------------------------------------------
package red_pitaya_fads_pkg;

  // Default width of delay / width / holdoff configuration fields (cycles).
  localparam int FADS_DW = 16;
  // Default width of the event counters.
  localparam int FADS_CW = 32;

  // Fluorescence level (signed 14-bit ADC code) the detector compares
  // against when deciding that a droplet is present.
  localparam logic signed [13:0] LOW_THRESHOLD = 14'sd200;

  // Sorter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_PULSE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } fads_state_t;

  // Debug view of the sorter: current state plus this cycle's trigger
  // classification.
  typedef struct packed {
    fads_state_t state;
    logic        trig_edge;
    logic        accept;
    logic        miss;
  } fads_dbg_t;

endpackage

// File: rtl/red_pitaya_fads_satcnt.sv
// -----------------------------------------------------------------------------
// red_pitaya_fads_satcnt
//   Saturating event counter. Counts cycles with inc=1, sticks at all-ones,
//   and returns to zero on reset or clear. Clear wins over a same-cycle inc.
//
// Ports:
//   adc_clk_i  clock
//   adc_rst_i  synchronous active-high reset
//   clear      one-cycle clear request
//   inc        count-enable for this cycle
//   cnt        current count
// -----------------------------------------------------------------------------
module red_pitaya_fads_satcnt
  import red_pitaya_fads_pkg::*;
#(
  parameter int CW = FADS_CW
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// -----------------------------------------------------------------------------
// red_pitaya_fads_sorter
//   Consumer end of the FADS trigger interface. Each accepted rising edge of
//   sort_trig_i runs one actuation: a programmable delay, then a gate of
//   programmable width whose first cycle also carries a one-cycle ASG start
//   strobe, then a holdoff window before the sorter re-arms. Edges that arrive
//   while a sort is in progress, or while disabled, are counted as missed.
//
// Ports:
//   adc_clk_i     ADC clock (single clock domain)
//   adc_rst_i     synchronous active-high reset
//   sort_trig_i   detector trigger level
//   enable_i      1 = accept new triggers
//   delay_i       cycles from trigger edge to gate start
//   width_i       gate length in cycles (0 behaves as 1)
//   holdoff_i     dead time after the gate before re-arming
//   clear_i       one-cycle pulse, zeroes both counters
//   asg_trig_o    one-cycle ASG start strobe
//   sort_gate_o   actuation gate
//   busy_o        high in every state except IDLE
//   sort_cnt_o    accepted sorts (saturating)
//   missed_cnt_o  dropped edges (saturating)
//   dbg_o         FSM state and trigger classification
// -----------------------------------------------------------------------------
module red_pitaya_fads_sorter
  import red_pitaya_fads_pkg::*;
#(
  parameter int DW = FADS_DW,
  parameter int CW = FADS_CW
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          sort_trig_i,
  input  logic          enable_i,
  input  logic [DW-1:0] delay_i,
  input  logic [DW-1:0] width_i,
  input  logic [DW-1:0] holdoff_i,
  input  logic          clear_i,
  output logic          asg_trig_o,
  output logic          sort_gate_o,
  output logic          busy_o,
  output logic [CW-1:0] sort_cnt_o,
  output logic [CW-1:0] missed_cnt_o,
  output fads_dbg_t     dbg_o
);

  // Down-counter preload for a gate of max(w,1) cycles.
  function automatic logic [DW-1:0] pulse_len_m1(input logic [DW-1:0] w);
    return (w == '0) ? '0 : (w - 1'b1);
  endfunction

  fads_state_t   state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] width_q, holdoff_q;
  logic          trig_q;
  logic          trig_edge, accept, miss;
  logic          asg_d, gate_d, busy_d;

  // trig_q resets high so a trigger already high at reset release is not
  // taken as an edge.
  assign trig_edge = sort_trig_i & ~trig_q;
  assign accept    = trig_edge & enable_i & (state_q == ST_IDLE);
  assign miss      = trig_edge & ~accept;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // delay_i is consumed here; width/holdoff are latched alongside.
          if (delay_i == '0) begin
            state_d = ST_PULSE;
            cnt_d   = pulse_len_m1(width_i);
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_i - 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = pulse_len_m1(width_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (holdoff_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = holdoff_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it describes and nothing is combinational from
  // the inputs. PULSE is only ever entered from another state, so the strobe
  // marks its first cycle.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    gate_d = (state_d == ST_PULSE);
    asg_d  = (state_d == ST_PULSE) && (state_q != ST_PULSE);
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      holdoff_q   <= '0;
      trig_q      <= 1'b1;
      asg_trig_o  <= 1'b0;
      sort_gate_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trig_q      <= sort_trig_i;
      asg_trig_o  <= asg_d;
      sort_gate_o <= gate_d;
      busy_o      <= busy_d;
      if (accept) begin
        width_q   <= width_i;
        holdoff_q <= holdoff_i;
      end
    end
  end

  red_pitaya_fads_satcnt #(.CW(CW)) u_sort_cnt (
    .adc_clk_i (adc_clk_i),
    .adc_rst_i (adc_rst_i),
    .clear     (clear_i),
    .inc       (accept),
    .cnt       (sort_cnt_o)
  );

  red_pitaya_fads_satcnt #(.CW(CW)) u_missed_cnt (
    .adc_clk_i (adc_clk_i),
    .adc_rst_i (adc_rst_i),
    .clear     (clear_i),
    .inc       (miss),
    .cnt       (missed_cnt_o)
  );

  assign dbg_o = '{state: state_q, trig_edge: trig_edge, accept: accept, miss: miss};

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_fads_sorter
//   Directed bench for the FADS sorter. A second instance with 2-bit counters
//   exercises counter saturation in a few cycles.
// -----------------------------------------------------------------------------
module tb_red_pitaya_fads_sorter;
  import red_pitaya_fads_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 32;
  localparam int SCW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst;
  logic          sort_trig, enable, clear;
  logic [DW-1:0] delay, width, holdoff;
  logic          asg_trig_o, sort_gate_o, busy_o;
  logic [CW-1:0] sort_cnt_o, missed_cnt_o;
  fads_dbg_t     dbg;

  logic           sat_trig, sat_clear;
  logic           sat_asg, sat_gate, sat_busy;
  logic [SCW-1:0] sat_sort_cnt, sat_missed_cnt;
  fads_dbg_t      sat_dbg;

  red_pitaya_fads_sorter #(.DW(DW), .CW(CW)) dut (
    .adc_clk_i    (clk),
    .adc_rst_i    (rst),
    .sort_trig_i  (sort_trig),
    .enable_i     (enable),
    .delay_i      (delay),
    .width_i      (width),
    .holdoff_i    (holdoff),
    .clear_i      (clear),
    .asg_trig_o   (asg_trig_o),
    .sort_gate_o  (sort_gate_o),
    .busy_o       (busy_o),
    .sort_cnt_o   (sort_cnt_o),
    .missed_cnt_o (missed_cnt_o),
    .dbg_o        (dbg)
  );

  red_pitaya_fads_sorter #(.DW(DW), .CW(SCW)) dut_sat (
    .adc_clk_i    (clk),
    .adc_rst_i    (rst),
    .sort_trig_i  (sat_trig),
    .enable_i     (enable),
    .delay_i      (delay),
    .width_i      (width),
    .holdoff_i    (holdoff),
    .clear_i      (sat_clear),
    .asg_trig_o   (sat_asg),
    .sort_gate_o  (sat_gate),
    .busy_o       (sat_busy),
    .sort_cnt_o   (sat_sort_cnt),
    .missed_cnt_o (sat_missed_cnt),
    .dbg_o        (sat_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int unsigned gate_cycles = 0;
  logic [31:0] exp_q[$];   // expected cycle label of each asg_trig_o strobe

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every strobe must match the next expected strobe cycle.
  always @(negedge clk) begin
    if (sort_gate_o) gate_cycles++;
    if (asg_trig_o) begin
      if (exp_q.size() == 0) check("asg_unexpected", 64'(exp_q.size()), 1);
      else                   check("asg_cycle", cyc, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Called at a negedge: raises the trigger for one cycle and checks gate,
  // strobe and busy every cycle until the sorter is back in IDLE.
  task automatic trace_sort(input int d, input int w, input int h);
    int weff, c0, s;
    weff = (w == 0) ? 1 : w;
    c0   = int'(cyc) + 1;
    exp_q.push_back(32'(c0 + d));
    sort_trig = 1'b1;
    for (int j = 0; j < d + weff + h + 1; j++) begin
      @(negedge clk);
      if (j == 0) sort_trig = 1'b0;
      s = int'(cyc);
      check("trace_gate", sort_gate_o, (s >= c0 + d) && (s < c0 + d + weff));
      check("trace_asg",  asg_trig_o,  (s == c0 + d));
      check("trace_busy", busy_o,      (s >= c0) && (s < c0 + d + weff + h));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int unsigned g0;

    rst = 1'b1; sort_trig = 1'b1; enable = 1'b1; clear = 1'b0;
    delay = 16'd10; width = 16'd5; holdoff = 16'd20;
    sat_trig = 1'b0; sat_clear = 1'b0;
    step(4);
    rst = 1'b0;
    step(1);
    check("rst_asg",    asg_trig_o, 0);
    check("rst_gate",   sort_gate_o, 0);
    check("rst_busy",   busy_o, 0);
    check("rst_sort",   sort_cnt_o, 0);
    check("rst_missed", missed_cnt_o, 0);
    check("rst_state",  dbg.state, ST_IDLE);

    // Trigger held high through reset release: no sort.
    step(5);
    check("hold_busy",   busy_o, 0);
    check("hold_sort",   sort_cnt_o, 0);
    check("hold_missed", missed_cnt_o, 0);
    sort_trig = 1'b0;
    step(2);

    // Single sort: delay 10, width 5, holdoff 20.
    trace_sort(10, 5, 20);
    check("t1_sort",   sort_cnt_o, 1);
    check("t1_missed", missed_cnt_o, 0);

    // Zero config: one-cycle gate, re-armed edge at t+3 accepted.
    pulse_clear();
    check("clr_sort", sort_cnt_o, 0);
    delay = '0; width = '0; holdoff = '0;
    trace_sort(0, 0, 0);
    step(1);
    trace_sort(0, 0, 0);
    check("t2_sort", sort_cnt_o, 2);

    // Edges during DELAY and HOLDOFF are missed.
    pulse_clear();
    delay = 16'd10; width = 16'd5; holdoff = 16'd20;
    g0 = gate_cycles;
    c0 = int'(cyc) + 1;
    exp_q.push_back(32'(c0 + 10));
    sort_trig = 1'b1; step(1); sort_trig = 1'b0;
    step(3);
    check("t3_in_delay", dbg.state, ST_DELAY);
    sort_trig = 1'b1; step(1); sort_trig = 1'b0;
    step(16);
    check("t3_in_holdoff", dbg.state, ST_HOLDOFF);
    sort_trig = 1'b1; step(1); sort_trig = 1'b0;
    step(20);
    check("t3_gate_len", gate_cycles - g0, 5);
    check("t3_sort",     sort_cnt_o, 1);
    check("t3_missed",   missed_cnt_o, 2);
    check("t3_idle",     busy_o, 0);

    // Enable drop mid-pulse and config change mid-sort.
    pulse_clear();
    delay = 16'd2; width = 16'd4; holdoff = 16'd3;
    g0 = gate_cycles;
    c0 = int'(cyc) + 1;
    exp_q.push_back(32'(c0 + 2));
    sort_trig = 1'b1; step(1); sort_trig = 1'b0;
    width = 16'd9; holdoff = 16'd0;
    step(2);
    check("t4_gate_on", sort_gate_o, 1);
    enable = 1'b0;
    step(6);
    check("t4_holdoff_latched", busy_o, 1);
    step(1);
    check("t4_rearmed", busy_o, 0);
    step(5);
    check("t4_gate_len", gate_cycles - g0, 4);
    check("t4_sort",     sort_cnt_o, 1);
    sort_trig = 1'b1; step(1); sort_trig = 1'b0;
    step(10);
    check("t4_dis_missed", missed_cnt_o, 1);
    check("t4_dis_sort",   sort_cnt_o, 1);
    check("t4_dis_nogate", gate_cycles - g0, 4);
    enable = 1'b1;

    // Clear coincident with an accepted edge.
    width = 16'd4; holdoff = 16'd3;
    g0 = gate_cycles;
    c0 = int'(cyc) + 1;
    exp_q.push_back(32'(c0 + 2));
    sort_trig = 1'b1; clear = 1'b1;
    step(1);
    sort_trig = 1'b0; clear = 1'b0;
    check("t5_clr_sort",   sort_cnt_o, 0);
    check("t5_clr_missed", missed_cnt_o, 0);
    check("t5_busy",       busy_o, 1);
    step(12);
    check("t5_gate_len", gate_cycles - g0, 4);
    check("t5_sort",     sort_cnt_o, 0);

    // Saturation on the 2-bit instance.
    delay = '0; width = '0; holdoff = '0;
    for (int i = 0; i < 5; i++) begin
      sat_trig = 1'b1; step(1); sat_trig = 1'b0; step(3);
      if (i == 2) check("sat_sort_3", sat_sort_cnt, 3);
    end
    check("sat_sort_stuck", sat_sort_cnt, 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sat_trig = 1'b1; step(1); sat_trig = 1'b0; step(1);
    end
    enable = 1'b1;
    check("sat_missed_stuck", sat_missed_cnt, 3);
    sat_clear = 1'b1; step(1); sat_clear = 1'b0;
    check("sat_clr_sort",   sat_sort_cnt, 0);
    check("sat_clr_missed", sat_missed_cnt, 0);
    check("sat_idle",       sat_dbg.state, ST_IDLE);
    check("main_untouched", missed_cnt_o, 0);

    // Reset mid-sort.
    width = 16'd10;
    c0 = int'(cyc) + 1;
    exp_q.push_back(32'(c0));
    sort_trig = 1'b1; step(1); sort_trig = 1'b0;
    step(2);
    check("t7_gate_pre", sort_gate_o, 1);
    rst = 1'b1;
    step(1);
    check("t7_gate_drop", sort_gate_o, 0);
    check("t7_busy",      busy_o, 0);
    check("t7_sort",      sort_cnt_o, 0);
    check("t7_state",     dbg.state, ST_IDLE);
    rst = 1'b0;
    step(3);
    check("t7_stay_idle", busy_o, 0);

    // ---------------- report ----------------
    check("sb_drain", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
